// File: rtl/piso_tx.sv
// Purpose : parallel-in serial-out transmitter, one word of WIDTH bits sent one bit per clock.
// Latency : first bit is on d in the cycle right after the transfer edge; words chain with no gap.
// Backpr. : one-word hold buffer behind the shift register; din_ready = !hold_full.
//
// Ports:
//   clk        single clock, all state on rising edge
//   rst_n      synchronous active-low reset
//   din        parallel word to serialize
//   din_valid  din holds a word offered for transfer
//   din_ready  a word can be accepted this cycle (transfer = din_valid & din_ready)
//   d          registered serial data bit (0 when not valid)
//   d_valid    registered, d carries a payload bit
//   d_last     d carries the final bit of a word
//   busy       shifting a word or holding a queued word
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             d,
    output logic             d_valid,
    output logic             d_last,
    output logic             busy
);

    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] r_hold;
    logic [CW-1:0]    r_cnt;
    logic             r_hold_full;
    logic             r_d;
    logic             r_d_valid;

    logic [WIDTH-1:0] w_sreg_nxt;
    logic [WIDTH-1:0] w_hold_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_hold_full_nxt;
    logic             w_d_nxt;
    logic             w_d_valid_nxt;

    logic             w_xfer;
    logic             w_cnt_last;

    // The bit on the wire is always the "send-side" end of sreg; shifting
    // moves the next bit into that position.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    assign w_xfer     = din_valid && !r_hold_full;
    assign w_cnt_last = (r_cnt == CNT_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // On the last bit, keep shifting only if another word is
                // already held or arrives on this very edge.
                if (w_cnt_last && !r_hold_full && !w_xfer) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- output / datapath next values ----------------
    always_comb begin
        w_sreg_nxt      = r_sreg;
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;
        w_cnt_nxt       = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_sreg_nxt = din;
                    w_cnt_nxt  = '0;
                end
            end
            ST_SHIFT: begin
                if (!w_cnt_last) begin
                    w_sreg_nxt = shift_word(r_sreg);
                    w_cnt_nxt  = r_cnt + CW'(1);
                    if (w_xfer) begin
                        w_hold_nxt      = din;
                        w_hold_full_nxt = 1'b1;
                    end
                end else if (r_hold_full) begin
                    // din_ready is low here, so no new word can collide.
                    w_sreg_nxt      = r_hold;
                    w_hold_full_nxt = 1'b0;
                    w_cnt_nxt       = '0;
                end else if (w_xfer) begin
                    // Hold is empty: bypass it and load the shifter directly.
                    w_sreg_nxt = din;
                    w_cnt_nxt  = '0;
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            default: begin
                w_cnt_nxt = '0;
            end
        endcase
        w_d_valid_nxt = (w_state_nxt == ST_SHIFT);
        w_d_nxt       = w_d_valid_nxt ? head_bit(w_sreg_nxt) : 1'b0;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sreg      <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_cnt       <= '0;
            r_d         <= 1'b0;
            r_d_valid   <= 1'b0;
        end else begin
            r_sreg      <= w_sreg_nxt;
            r_hold      <= w_hold_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_cnt       <= w_cnt_nxt;
            r_d         <= w_d_nxt;
            r_d_valid   <= w_d_valid_nxt;
        end
    end

    assign din_ready = !r_hold_full;
    assign d         = r_d;
    assign d_valid   = r_d_valid;
    assign d_last    = r_d_valid && w_cnt_last;
    assign busy      = (r_state == ST_SHIFT) || r_hold_full;

endmodule
